// File: rtl/vc_crossbar3_sw_alloc_pkg.sv
// Shared encodings for the 3x3 crossbar switch allocator.
// Optional counter feature: VC_CROSSBAR3_SW_ALLOC_CNT_EN.
package vc_crossbar3_sw_alloc_pkg;

    localparam int unsigned N_PORTS = 3;
    localparam int unsigned IDX_W   = 2;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_st_e;

    localparam logic [IDX_W-1:0] SEL_IN0      = 2'd0;
    localparam logic [IDX_W-1:0] SEL_IN1      = 2'd1;
    localparam logic [IDX_W-1:0] SEL_IN2      = 2'd2;
    localparam logic [IDX_W-1:0] DEST_INVALID = 2'd3;

    // Round-robin successor over inputs 0..2 (2 wraps to 0).
    function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] idx);
        logic [IDX_W-1:0] nxt;
        case (idx)
            SEL_IN0: nxt = SEL_IN1;
            SEL_IN1: nxt = SEL_IN2;
            default: nxt = SEL_IN0;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/vc_crossbar3_sw_alloc_if.sv
// Request/grant bundle between the crossbar input stage and the switch allocator.
// Counter signals exist only with VC_CROSSBAR3_SW_ALLOC_CNT_EN.
interface vc_crossbar3_sw_alloc_if
`ifdef VC_CROSSBAR3_SW_ALLOC_CNT_EN
    #(parameter int unsigned p_cnt_nbits = 16)
`endif
    ;
    logic [2:0] in_val;
    logic [1:0] in_dest0;
    logic [1:0] in_dest1;
    logic [1:0] in_dest2;
    logic [2:0] in_tail;
    logic [2:0] in_rdy;
    logic [2:0] out_rdy;
    logic [2:0] out_val;
    logic [1:0] sel0;
    logic [1:0] sel1;
    logic [1:0] sel2;
`ifdef VC_CROSSBAR3_SW_ALLOC_CNT_EN
    logic [p_cnt_nbits-1:0] cnt0;
    logic [p_cnt_nbits-1:0] cnt1;
    logic [p_cnt_nbits-1:0] cnt2;
`endif

    modport master (
        output in_val, in_dest0, in_dest1, in_dest2, in_tail, out_rdy,
        input  in_rdy, out_val, sel0, sel1, sel2
`ifdef VC_CROSSBAR3_SW_ALLOC_CNT_EN
        , input cnt0, cnt1, cnt2
`endif
    );

    modport slave (
        input  in_val, in_dest0, in_dest1, in_dest2, in_tail, out_rdy,
        output in_rdy, out_val, sel0, sel1, sel2
`ifdef VC_CROSSBAR3_SW_ALLOC_CNT_EN
        , output cnt0, cnt1, cnt2
`endif
    );

endinterface

// File: rtl/vc_crossbar3_sw_alloc_rr_arb3_lock.sv
// Per-output round-robin arbiter with wormhole lock (vc_RRArb3Lock role).
// Grant is combinational; state advances only when the grant fires or on flush.
module vc_crossbar3_sw_alloc_rr_arb3_lock
    import vc_crossbar3_sw_alloc_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               flush,
    input  logic [N_PORTS-1:0] req,
    input  logic [N_PORTS-1:0] tail,
    input  logic               out_rdy,
    output logic               gnt_val_c,
    output logic [IDX_W-1:0]   gnt_idx_c
);

    arb_st_e          st_q,    st_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [IDX_W-1:0] ptr_q,   ptr_d;
    logic [IDX_W-1:0] cand;
    logic             gnt_val;
    logic [IDX_W-1:0] gnt_idx;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st_q    <= ST_IDLE;
            owner_q <= SEL_IN0;
            ptr_q   <= SEL_IN0;
        end else begin
            st_q    <= st_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        st_d    = st_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        gnt_val = 1'b0;
        gnt_idx = SEL_IN0;
        cand    = ptr_q;

        // A locked output serves only its owner and stalls otherwise.
        if (st_q == ST_LOCKED) begin
            if (req[owner_q]) begin
                gnt_val = 1'b1;
                gnt_idx = owner_q;
            end
        end else begin
            for (int unsigned k = 0; k < N_PORTS; k++) begin
                if (!gnt_val && req[cand]) begin
                    gnt_val = 1'b1;
                    gnt_idx = cand;
                end
                cand = rr_next(cand);
            end
        end

        if (flush) begin
            st_d    = ST_IDLE;
            owner_d = SEL_IN0;
            ptr_d   = SEL_IN0;
        end else if (gnt_val && out_rdy) begin
            ptr_d = rr_next(gnt_idx);
            if (st_q == ST_IDLE && !tail[gnt_idx]) begin
                st_d    = ST_LOCKED;
                owner_d = gnt_idx;
            end else if (st_q == ST_LOCKED && tail[gnt_idx]) begin
                st_d = ST_IDLE;
            end
        end
    end

    assign gnt_val_c = gnt_val;
    assign gnt_idx_c = gnt_idx;

endmodule

// File: rtl/vc_crossbar3_sw_alloc.sv
// Switch allocator feeding the 3x3 crossbar: per-output wormhole round-robin,
// domain-switch flush. Optional transfer counters: VC_CROSSBAR3_SW_ALLOC_CNT_EN.
module vc_crossbar3_sw_alloc
    import vc_crossbar3_sw_alloc_pkg::*;
`ifdef VC_CROSSBAR3_SW_ALLOC_CNT_EN
    #(parameter int unsigned p_cnt_nbits = 16)
`endif
(
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   sd,
    vc_crossbar3_sw_alloc_if.slave bus
);

    logic               sd_q;
    logic               dom_sw;
    logic [IDX_W-1:0]   dest    [N_PORTS];
    logic [N_PORTS-1:0] req_to  [N_PORTS];
    logic [N_PORTS-1:0] gnt_val;
    logic [IDX_W-1:0]   gnt_idx [N_PORTS];
    logic [N_PORTS-1:0] fire;
    logic [N_PORTS-1:0] in_rdy_c;

    assign dest[0] = bus.in_dest0;
    assign dest[1] = bus.in_dest1;
    assign dest[2] = bus.in_dest2;

    // A domain change kills every grant this cycle and flushes history.
    assign dom_sw = (sd != sd_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sd_q <= 1'b0;
        else          sd_q <= sd;
    end

    // req_to[o][i]: input i asks for output o; masked during reset and domain switch.
    always_comb begin
        for (int unsigned o = 0; o < N_PORTS; o++) begin
            req_to[o] = '0;
            for (int unsigned i = 0; i < N_PORTS; i++) begin
                req_to[o][i] = reset_n && !dom_sw && bus.in_val[i] &&
                               (dest[i] != DEST_INVALID) && (dest[i] == IDX_W'(o));
            end
        end
    end

    for (genvar o = 0; o < N_PORTS; o++) begin : g_arb
        vc_crossbar3_sw_alloc_rr_arb3_lock u_arb (
            .clk       (clk),
            .reset_n   (reset_n),
            .flush     (dom_sw),
            .req       (req_to[o]),
            .tail      (bus.in_tail),
            .out_rdy   (bus.out_rdy[o]),
            .gnt_val_c (gnt_val[o]),
            .gnt_idx_c (gnt_idx[o])
        );
    end

    assign fire = gnt_val & bus.out_rdy;

    // Each input targets one output, so at most one fire maps to any input.
    always_comb begin
        in_rdy_c = '0;
        for (int unsigned o = 0; o < N_PORTS; o++) begin
            if (fire[o]) in_rdy_c[gnt_idx[o]] = 1'b1;
        end
    end

    assign bus.in_rdy  = in_rdy_c;
    assign bus.out_val = gnt_val;
    assign bus.sel0    = gnt_idx[0];
    assign bus.sel1    = gnt_idx[1];
    assign bus.sel2    = gnt_idx[2];

`ifdef VC_CROSSBAR3_SW_ALLOC_CNT_EN
    logic [p_cnt_nbits-1:0] cnt_q [N_PORTS];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned o = 0; o < N_PORTS; o++) cnt_q[o] <= '0;
        end else begin
            for (int unsigned o = 0; o < N_PORTS; o++) begin
                if (dom_sw)       cnt_q[o] <= '0;
                else if (fire[o]) cnt_q[o] <= cnt_q[o] + p_cnt_nbits'(1);
            end
        end
    end

    assign bus.cnt0 = cnt_q[0];
    assign bus.cnt1 = cnt_q[1];
    assign bus.cnt2 = cnt_q[2];
`endif

endmodule

// File: tb/tb_vc_crossbar3_sw_alloc.sv
// Directed scoreboard bench for vc_crossbar3_sw_alloc.
// Counter checks run when VC_CROSSBAR3_SW_ALLOC_CNT_EN is defined (width 2).
module tb_vc_crossbar3_sw_alloc;

    localparam int unsigned TB_CNT_W = 2;

    typedef struct {
        string      tag;
        logic [2:0] ov;
        logic [2:0] ir;
        logic [1:0] s0;
        logic [1:0] s1;
        logic [1:0] s2;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    logic sd;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

`ifdef VC_CROSSBAR3_SW_ALLOC_CNT_EN
    vc_crossbar3_sw_alloc_if #(.p_cnt_nbits(TB_CNT_W)) bus ();
    vc_crossbar3_sw_alloc #(.p_cnt_nbits(TB_CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .sd(sd), .bus(bus));
`else
    vc_crossbar3_sw_alloc_if bus ();
    vc_crossbar3_sw_alloc dut (
        .clk(clk), .reset_n(reset_n), .sd(sd), .bus(bus));
`endif

    task automatic drive(input logic [2:0] val, input logic [1:0] d0, input logic [1:0] d1,
                         input logic [1:0] d2, input logic [2:0] tail, input logic [2:0] ordy);
        bus.in_val   = val;
        bus.in_dest0 = d0;
        bus.in_dest1 = d1;
        bus.in_dest2 = d2;
        bus.in_tail  = tail;
        bus.out_rdy  = ordy;
    endtask

    task automatic expect_out(input string tag, input logic [2:0] ov, input logic [2:0] ir,
                              input logic [1:0] s0, input logic [1:0] s1, input logic [1:0] s2);
        exp_t e;
        e.tag = tag; e.ov = ov; e.ir = ir; e.s0 = s0; e.s1 = s1; e.s2 = s2;
        exp_q.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: observed no expected entry, required one");
        end else begin
            e = exp_q.pop_front();
            assert ({bus.out_val, bus.in_rdy, bus.sel0, bus.sel1, bus.sel2} ===
                    {e.ov, e.ir, e.s0, e.s1, e.s2})
            else begin
                errors++;
                $error("FAIL %s: observed out_val=%b in_rdy=%b sel=%0d/%0d/%0d, expected out_val=%b in_rdy=%b sel=%0d/%0d/%0d",
                       e.tag, bus.out_val, bus.in_rdy, bus.sel0, bus.sel1, bus.sel2,
                       e.ov, e.ir, e.s0, e.s1, e.s2);
            end
        end
    endtask

    // One cycle: drive at the falling edge, compare mid-cycle, advance past the rising edge.
    task automatic step(input string tag, input logic [2:0] val, input logic [1:0] d0,
                        input logic [1:0] d1, input logic [1:0] d2, input logic [2:0] tail,
                        input logic [2:0] ordy, input logic [2:0] ov, input logic [2:0] ir,
                        input logic [1:0] s0, input logic [1:0] s1, input logic [1:0] s2);
        drive(val, d0, d1, d2, tail, ordy);
        expect_out(tag, ov, ir, s0, s1, s2);
        #2;
        check_out();
        @(negedge clk);
    endtask

`ifdef VC_CROSSBAR3_SW_ALLOC_CNT_EN
    task automatic check_cnt(input string tag, input logic [TB_CNT_W-1:0] e0,
                             input logic [TB_CNT_W-1:0] e1, input logic [TB_CNT_W-1:0] e2);
        checks++;
        assert ({bus.cnt0, bus.cnt1, bus.cnt2} === {e0, e1, e2})
        else begin
            errors++;
            $error("FAIL %s: observed cnt=%0d/%0d/%0d, expected cnt=%0d/%0d/%0d",
                   tag, bus.cnt0, bus.cnt1, bus.cnt2, e0, e1, e2);
        end
    endtask
`endif

    initial begin
        reset_n = 1'b0;
        sd      = 1'b0;
        // Requests present during reset must not produce grants.
        step("reset", 3'b111, 2'd0, 2'd0, 2'd0, 3'b111, 3'b111, 3'b000, 3'b000, 2'd0, 2'd0, 2'd0);
        reset_n = 1'b1;

        // Round robin on out0 with single-flit packets.
        step("rr_in0",  3'b111, 2'd0, 2'd0, 2'd0, 3'b111, 3'b001, 3'b001, 3'b001, 2'd0, 2'd0, 2'd0);
        step("rr_in1",  3'b111, 2'd0, 2'd0, 2'd0, 3'b111, 3'b001, 3'b001, 3'b010, 2'd1, 2'd0, 2'd0);
        step("rr_in2",  3'b111, 2'd0, 2'd0, 2'd0, 3'b111, 3'b001, 3'b001, 3'b100, 2'd2, 2'd0, 2'd0);
        step("rr_wrap", 3'b111, 2'd0, 2'd0, 2'd0, 3'b111, 3'b001, 3'b001, 3'b001, 2'd0, 2'd0, 2'd0);
        // Grant visible without out_rdy; no fire, pointer holds at in1.
        step("no_rdy",  3'b111, 2'd0, 2'd0, 2'd0, 3'b111, 3'b000, 3'b001, 3'b000, 2'd1, 2'd0, 2'd0);

        // Wormhole: in0 3-flit packet to out1 while in2 competes.
        step("pkt_f1",     3'b101, 2'd1, 2'd0, 2'd1, 3'b000, 3'b111, 3'b010, 3'b001, 2'd0, 2'd0, 2'd0);
        step("pkt_f2",     3'b101, 2'd1, 2'd0, 2'd1, 3'b000, 3'b111, 3'b010, 3'b001, 2'd0, 2'd0, 2'd0);
        step("lock_stall", 3'b100, 2'd1, 2'd0, 2'd1, 3'b000, 3'b111, 3'b000, 3'b000, 2'd0, 2'd0, 2'd0);
        step("pkt_tail",   3'b101, 2'd1, 2'd0, 2'd1, 3'b001, 3'b111, 3'b010, 3'b001, 2'd0, 2'd0, 2'd0);
        step("in2_after",  3'b100, 2'd1, 2'd0, 2'd1, 3'b100, 3'b111, 3'b010, 3'b100, 2'd0, 2'd2, 2'd0);

        // Three parallel transfers.
        step("parallel", 3'b111, 2'd0, 2'd1, 2'd2, 3'b111, 3'b111, 3'b111, 3'b111, 2'd0, 2'd1, 2'd2);

        // Invalid destination.
        step("dest3_only", 3'b010, 2'd0, 2'd3, 2'd0, 3'b111, 3'b111, 3'b000, 3'b000, 2'd0, 2'd0, 2'd0);
        step("dest3_mix",  3'b011, 2'd0, 2'd3, 2'd0, 3'b111, 3'b111, 3'b001, 3'b001, 2'd0, 2'd0, 2'd0);

        // Lock out2 to in1, then flip the domain mid-packet.
        step("lock_out2", 3'b010, 2'd0, 2'd2, 2'd0, 3'b000, 3'b111, 3'b100, 3'b010, 2'd0, 2'd0, 2'd1);
        sd = 1'b1;
        step("dom_sw",    3'b010, 2'd0, 2'd2, 2'd0, 3'b000, 3'b111, 3'b000, 3'b000, 2'd0, 2'd0, 2'd0);
        step("post_sw",   3'b101, 2'd2, 2'd0, 2'd2, 3'b111, 3'b111, 3'b100, 3'b001, 2'd0, 2'd0, 2'd0);

        // Relock out2, then async reset in the middle of a cycle.
        step("relock", 3'b010, 2'd0, 2'd2, 2'd0, 3'b000, 3'b111, 3'b100, 3'b010, 2'd0, 2'd0, 2'd1);
        drive(3'b111, 2'd2, 2'd2, 2'd2, 3'b000, 3'b111);
        expect_out("lock_hold", 3'b100, 3'b010, 2'd0, 2'd0, 2'd1);
        #2;
        check_out();
        #1;
        reset_n = 1'b0;
        sd      = 1'b0;
        expect_out("async_rst", 3'b000, 3'b000, 2'd0, 2'd0, 2'd0);
        #1;
        check_out();
        @(negedge clk);
        reset_n = 1'b1;
        step("post_rst", 3'b101, 2'd2, 2'd0, 2'd2, 3'b111, 3'b111, 3'b100, 3'b001, 2'd0, 2'd0, 2'd0);

        // Five flits through out0.
        for (int n = 0; n < 5; n++) begin
            step("out0_burst", 3'b001, 2'd0, 2'd0, 2'd0, 3'b111, 3'b001, 3'b001, 3'b001, 2'd0, 2'd0, 2'd0);
        end
        drive(3'b000, 2'd0, 2'd0, 2'd0, 3'b000, 3'b000);
        #2;
`ifdef VC_CROSSBAR3_SW_ALLOC_CNT_EN
        check_cnt("cnt_wrap", 2'd1, 2'd0, 2'd1);
`endif
        @(negedge clk);
        sd = 1'b1;
        step("sw_idle", 3'b001, 2'd0, 2'd0, 2'd0, 3'b111, 3'b001, 3'b000, 3'b000, 2'd0, 2'd0, 2'd0);
`ifdef VC_CROSSBAR3_SW_ALLOC_CNT_EN
        #2;
        check_cnt("cnt_clear", 2'd0, 2'd0, 2'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vc_crossbar3_sw_alloc.md
Name: vc_crossbar3_sw_alloc

Overview:
- Switch allocator that sits directly upstream of the 3-input/3-output crossbar.
- Takes per-input valid/destination/tail requests and per-output ready.
- Produces the crossbar's three 2-bit select lines, per-output valid and per-input ready.
- Uses per-output round-robin arbitration with wormhole (multi-flit packet) locking.
- All request/grant signals are in the security domain given by `sd`.

Parameters:
- p_cnt_nbits, 16, width of the optional per-output transfer counters (used only when the optional feature is enabled).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- sd  input  1  security domain label {L}; every other port carries {Domain sd}.
- in_val  input  3  bit i: input i presents a flit.
- in_dest0..in_dest2  input  2 each  destination output of input i; value 3 is invalid.
- in_tail  input  3  bit i: the flit on input i is the last flit of its packet.
- in_rdy  output  3  bit i: input i's flit is accepted this cycle.
- out_rdy  input  3  bit o: downstream of output o can accept a flit.
- out_val  output  3  bit o: output o carries a granted flit.
- sel0..sel2  output  2 each  crossbar select for output o; encoding 0/1/2 = in0/in1/in2.
- cnt0..cnt2  output  p_cnt_nbits each  transfer counters; present only with the optional feature.

Behaviour:
- Per-output state:
  - st_o: IDLE or LOCKED.
  - owner_o: 2 bits.
  - ptr_o: 2 bits, the highest-priority input, range 0..2.
  - sd_q: 1 bit, the registered value of sd.
- Request: req[i][o] = in_val[i] && in_dest_i == o. An input with dest 3 never requests, is never granted, and sees in_rdy = 0.
- IDLE grant: the first requesting input scanning ptr_o, ptr_o+1, ptr_o+2 (mod 3, so 2 wraps to 0).
- LOCKED grant: owner_o only if req[owner_o][o]. If the owner is idle or points elsewhere, output o stalls and stays LOCKED.
- Grant timing: combinational, zero latency.
  - out_val[o] = a grant exists.
  - sel_o = the granted index; sel_o = 0 when there is no grant.
  - out_val and sel never depend on out_rdy.
- Handshake: in_rdy[i] = granted at in_dest_i && out_rdy[in_dest_i]. fire_o = out_val[o] && out_rdy[o].
- Transitions on fire_o from input i:
  - In IDLE, if the flit is not a tail: go to LOCKED with owner_o = i.
  - In IDLE, if the flit is a tail: stay IDLE.
  - In LOCKED, if the flit is a tail: go to IDLE.
  - In all cases: ptr_o = (i+1) mod 3.
- No fire: state and pointers hold.
- An input targets exactly one output per cycle, so no input-side conflict exists. Three simultaneous fires to three distinct outputs are legal.
- Domain switch: whenever sd != sd_q, in that cycle:
  - all grants are suppressed: out_val = 0, in_rdy = 0, sel = 0;
  - next state is all IDLE, ptr = 0, owner = 0;
  - sd_q <= sd.
  - This prevents arbitration history crossing domains.
- Reset (async, any time, including mid-packet) sets: all st IDLE, ptr = 0, owner = 0, sd_q = 0, counters = 0. While reset_n = 0, out_val = 0, in_rdy = 0, sel = 0.

Optional Feature:
- Macro: VC_CROSSBAR3_SW_ALLOC_CNT_EN.
- Defined:
  - cnt0..cnt2 exist.
  - cnt_o increments by 1 on every fire_o and wraps modulo 2^p_cnt_nbits.
  - Counters clear on reset and on a domain switch.
- Undefined: the counter ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - state encoding (IDLE = 0, LOCKED = 1);
  - select encoding constants for in0/in1/in2;
  - the invalid-destination constant 3.
- One natural sub-module, vc_RRArb3Lock: the per-output arbiter containing st/owner/ptr. It is instantiated three times; the top level holds sd_q, the request matrix, the in_rdy merge and the counters.

Test Plan:
1. Reset then sd = 0 steady, in_val = 3'b111, all dest 0, all tail = 1, out_rdy = 3'b001 for 3 cycles -> grants go to in0, in1, in2 in order; ptr0 returns to 0; out_val = 3'b001 throughout.
2. in0 sends a 3-flit packet to out1 (tail on flit 3) while in2 also requests out1 -> in2 is blocked until in0's tail fires; then in2 is granted with sel1 = 2.
3. in0 → out0, in1 → out1, in2 → out2, all ready -> in_rdy = 3'b111 and out_val = 3'b111 in the same cycle; sel0/1/2 = 0/1/2.
4. in1 sets dest = 3 with in_val = 1 -> in_rdy[1] = 0 and no out_val asserted.
5. Mid-packet (out2 LOCKED, owner 1), toggle sd -> that cycle out_val = 0 and in_rdy = 0; next cycle out2 is IDLE with ptr = 0. Assert reset_n = 0 mid-packet -> outputs go to 0 asynchronously.
6. With VC_CROSSBAR3_SW_ALLOC_CNT_EN and p_cnt_nbits = 2, send 5 flits through out0 -> cnt0 = 1 (wrap).
